// File: rtl/ulpi_pkg.sv
// Shared ULPI link definitions: TX CMD encodings, link FSM states, RX CMD field layout.
package ulpi_pkg;

   localparam logic [1:0] TXCMD_REGW = 2'b10;
   localparam logic [1:0] TXCMD_REGR = 2'b11;
   localparam logic [7:0] TXCMD_IDLE = 8'h00;

   localparam int RXCMD_LINE_LSB  = 0;
   localparam int RXCMD_VBUS_LSB  = 2;
   localparam int RXCMD_EVENT_LSB = 4;
   localparam int RXCMD_FIELD_W   = 2;

   typedef enum logic [2:0] {
      IDLE,
      TXCMD,
      WDATA,
      STP,
      RTURN1,
      RDATA,
      RTURN2
   } link_state_e;

   typedef struct packed {
      logic       read;
      logic [5:0] addr;
      logic [7:0] wdata;
   } reg_req_t;

   function automatic logic [7:0] txcmd_byte(input logic read, input logic [5:0] addr);
      return {(read ? TXCMD_REGR : TXCMD_REGW), addr};
   endfunction

endpackage

// File: rtl/ulpi_link_rx.sv
// ULPI receive path: bus turnaround detection and capture of RX CMD / packet bytes.
module ulpi_link_rx (
   input  logic       clk,
   input  logic       reset,
   input  logic       dir_i,
   input  logic       nxt_i,
   input  logic [7:0] data_i,
   input  logic       capture_en_i,
   output logic       dir_q_o,
   output logic       rx_active_o,
   output logic [7:0] rx_cmd_o,
   output logic       rx_cmd_valid_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o
);

   logic       dir_q;
   logic [7:0] rx_cmd_q, rx_cmd_d;
   logic       rx_cmd_valid_q, rx_cmd_valid_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       turnaround;
   logic       rx_active;

   assign turnaround = (dir_i != dir_q);
   assign rx_active  = dir_i && !turnaround;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rx_cmd_d       = rx_cmd_q;
      rx_cmd_valid_d = 1'b0;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      if (rx_active && capture_en_i) begin
         if (nxt_i) begin
            rx_data_d  = data_i;
            rx_valid_d = 1'b1;
         end else begin
            rx_cmd_d       = data_i;
            rx_cmd_valid_d = 1'b1;
         end
      end
   end

   // NOTE: clocked state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dir_q          <= 1'b0;
         rx_cmd_q       <= 8'h00;
         rx_cmd_valid_q <= 1'b0;
         rx_data_q      <= 8'h00;
         rx_valid_q     <= 1'b0;
      end else begin
         dir_q          <= dir_i;
         rx_cmd_q       <= rx_cmd_d;
         rx_cmd_valid_q <= rx_cmd_valid_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
      end
   end

   assign dir_q_o        = dir_q;
   assign rx_active_o    = rx_active;
   assign rx_cmd_o       = rx_cmd_q;
   assign rx_cmd_valid_o = rx_cmd_valid_q;
   assign rx_data_o      = rx_data_q;
   assign rx_valid_o     = rx_valid_q;

endmodule

// File: rtl/ulpi_link.sv
// ULPI link-layer controller: register write/read TX CMDs plus RX CMD/packet receive.
// Optional RX CMD field decode enabled by defining ULPI_RXCMD_DECODE_EN.
module ulpi_link
   import ulpi_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   inout  wire  [7:0] data,
   input  logic       dir,
   input  logic       nxt,
   output logic       stp,
   input  logic [5:0] reg_addr,
   input  logic [7:0] reg_data_write,
   input  logic       reg_read_nwrite,
   input  logic       reg_enable,
   output logic       reg_done,
   output logic [7:0] reg_data_read,
   output logic [7:0] rx_cmd,
   output logic       rx_cmd_valid,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic [1:0] line_state,
   output logic [1:0] vbus_state,
   output logic [1:0] rx_event
);

   link_state_e state_q, state_d;
   reg_req_t    req_q, req_d;
   logic        req_valid_q, req_valid_d;
   logic [7:0]  reg_data_read_q, reg_data_read_d;
   logic        dir_q;
   logic        rx_active;
   logic        accept;
   logic        drive_en;
   logic [7:0]  tx_byte;

   ulpi_link_rx u_rx (
      .clk            (clk),
      .reset          (reset),
      .dir_i          (dir),
      .nxt_i          (nxt),
      .data_i         (data),
      .capture_en_i   (state_q != RDATA),
      .dir_q_o        (dir_q),
      .rx_active_o    (rx_active),
      .rx_cmd_o       (rx_cmd),
      .rx_cmd_valid_o (rx_cmd_valid),
      .rx_data_o      (rx_data),
      .rx_valid_o     (rx_valid)
   );

   assign accept = (state_q == IDLE) && !req_valid_q && reg_enable;

   always_comb begin
      state_d         = state_q;
      req_d           = req_q;
      req_valid_d     = req_valid_q;
      reg_data_read_d = reg_data_read_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               req_d       = '{read: reg_read_nwrite, addr: reg_addr, wdata: reg_data_write};
               req_valid_d = 1'b1;
            end
            if ((accept || req_valid_q) && !dir)
               state_d = TXCMD;
         end
         // A PHY taking the bus mid-command aborts it; the request stays pending.
         TXCMD: begin
            if (dir)
               state_d = IDLE;
            else if (nxt)
               state_d = req_q.read ? RTURN1 : WDATA;
         end
         WDATA: begin
            if (dir)
               state_d = IDLE;
            else if (nxt)
               state_d = STP;
         end
         STP: begin
            state_d     = IDLE;
            req_valid_d = 1'b0;
         end
         RTURN1: begin
            if (dir)
               state_d = RDATA;
         end
         RDATA: begin
            if (rx_active) begin
               reg_data_read_d = data;
               state_d         = RTURN2;
            end else if (!dir) begin
               state_d = IDLE;
            end
         end
         RTURN2: begin
            if (!dir_q) begin
               state_d     = IDLE;
               req_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= IDLE;
         req_q           <= '0;
         req_valid_q     <= 1'b0;
         reg_data_read_q <= 8'h00;
      end else begin
         state_q         <= state_d;
         req_q           <= req_d;
         req_valid_q     <= req_valid_d;
         reg_data_read_q <= reg_data_read_d;
      end
   end

   always_comb begin
      tx_byte = TXCMD_IDLE;
      case (state_q)
         TXCMD:   tx_byte = txcmd_byte(req_q.read, req_q.addr);
         WDATA:   tx_byte = req_q.wdata;
         default: tx_byte = TXCMD_IDLE;
      endcase
   end

   // The link only drives once both current and registered dir show link ownership.
   assign drive_en      = !dir && !dir_q;
   assign data          = drive_en ? tx_byte : 8'hzz;
   assign stp           = (state_q == STP) && !dir;
   assign reg_done      = (state_q == STP) || ((state_q == RTURN2) && !dir_q);
   assign reg_data_read = reg_data_read_q;

`ifdef ULPI_RXCMD_DECODE_EN
   assign line_state = rx_cmd[RXCMD_LINE_LSB  +: RXCMD_FIELD_W];
   assign vbus_state = rx_cmd[RXCMD_VBUS_LSB  +: RXCMD_FIELD_W];
   assign rx_event   = rx_cmd[RXCMD_EVENT_LSB +: RXCMD_FIELD_W];
`else
   assign line_state = 2'b00;
   assign vbus_state = 2'b00;
   assign rx_event   = 2'b00;
`endif

endmodule

// File: tb/tb_ulpi_link.sv
// Self-checking bench for ulpi_link: per-cycle vector table, RX scoreboard, reset corner cases.
module tb_ulpi_link;

   logic       clk = 1'b0;
   logic       reset;
   logic       dir;
   logic       nxt;
   logic [5:0] reg_addr;
   logic [7:0] reg_data_write;
   logic       reg_read_nwrite;
   logic       reg_enable;
   logic [7:0] phy_data;
   wire  [7:0] data;
   logic       stp;
   logic       reg_done;
   logic [7:0] reg_data_read;
   logic [7:0] rx_cmd;
   logic       rx_cmd_valid;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [1:0] line_state;
   logic [1:0] vbus_state;
   logic [1:0] rx_event;

   always #5 clk = ~clk;

   // Model PHY drives the bus whenever it owns it.
   assign data = dir ? phy_data : 8'hzz;

   ulpi_link dut (
      .clk             (clk),
      .reset           (reset),
      .data            (data),
      .dir             (dir),
      .nxt             (nxt),
      .stp             (stp),
      .reg_addr        (reg_addr),
      .reg_data_write  (reg_data_write),
      .reg_read_nwrite (reg_read_nwrite),
      .reg_enable      (reg_enable),
      .reg_done        (reg_done),
      .reg_data_read   (reg_data_read),
      .rx_cmd          (rx_cmd),
      .rx_cmd_valid    (rx_cmd_valid),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .line_state      (line_state),
      .vbus_state      (vbus_state),
      .rx_event        (rx_event)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int cmdv_cnt = 0;
   int rxv_cnt  = 0;
   logic [7:0] cmd_q[$];
   logic [7:0] pkt_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every byte the PHY presents outside turnaround is expected back once.
   always @(negedge clk) begin
      if (rx_cmd_valid === 1'b1) begin
         cmdv_cnt++;
         if (cmd_q.size() == 0) check("rx_cmd expected", 32'(cmd_q.size()), 32'd1);
         else check("rx_cmd", rx_cmd, cmd_q.pop_front());
      end
      if (rx_valid === 1'b1) begin
         rxv_cnt++;
         if (pkt_q.size() == 0) check("rx_data expected", 32'(pkt_q.size()), 32'd1);
         else check("rx_data", rx_data, pkt_q.pop_front());
      end
      if (reg_done === 1'b1) done_cnt++;
   end

   typedef struct {
      logic       en;
      logic       rnw;
      logic [5:0] addr;
      logic [7:0] wdata;
      logic       d;
      logic       n;
      logic [7:0] p;
      int         push;     // 0 none, 1 RX CMD, 2 packet byte
      logic       chk;
      logic [7:0] e_data;
      logic       e_stp;
      logic       e_done;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic en, input logic rnw, input logic [5:0] addr,
                               input logic [7:0] wdata, input logic d, input logic n,
                               input logic [7:0] p, input int push, input logic chk,
                               input logic [7:0] e_data, input logic e_stp, input logic e_done);
      vec_t v;
      v = '{en: en, rnw: rnw, addr: addr, wdata: wdata, d: d, n: n, p: p, push: push,
            chk: chk, e_data: e_data, e_stp: e_stp, e_done: e_done};
      return v;
   endfunction

   function automatic vec_t bus(input logic d, input logic n, input logic [7:0] p, input int push,
                                input logic chk, input logic [7:0] e_data,
                                input logic e_stp, input logic e_done);
      return mk(1'b0, 1'b0, 6'h00, 8'hFF, d, n, p, push, chk, e_data, e_stp, e_done);
   endfunction

   // Each row: check outputs now, then drive the row's inputs through the next rising edge.
   task automatic run_vecs();
      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         check($sformatf("row%0d stp", i), stp, v.e_stp);
         check($sformatf("row%0d reg_done", i), reg_done, v.e_done);
         if (v.chk) check($sformatf("row%0d data", i), data, v.e_data);
         reg_enable      = v.en;
         reg_read_nwrite = v.rnw;
         reg_addr        = v.addr;
         reg_data_write  = v.wdata;
         dir             = v.d;
         nxt             = v.n;
         phy_data        = v.p;
         if (v.push == 1) cmd_q.push_back(v.p);
         else if (v.push == 2) pkt_q.push_back(v.p);
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; dir = 1'b0; nxt = 1'b0; phy_data = 8'h00;
      reg_enable = 1'b0; reg_read_nwrite = 1'b0; reg_addr = 6'h00; reg_data_write = 8'h00;

      // RX CMDs 0x23 and 0x42, each behind its own dir-rise turnaround.
      vecs.push_back(bus(1'b1, 1'b0, 8'h23, 0, 1'b1, 8'h00, 1'b0, 1'b0));
      vecs.push_back(bus(1'b1, 1'b0, 8'h23, 1, 1'b1, 8'h23, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h23, 1'b0, 1'b0));
      vecs.push_back(bus(1'b1, 1'b0, 8'h42, 0, 1'b1, 8'h00, 1'b0, 1'b0));
      vecs.push_back(bus(1'b1, 1'b0, 8'h42, 1, 1'b1, 8'h42, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h42, 1'b0, 1'b0));
      // Packet of 4 bytes; nxt already high during the turnaround cycle.
      vecs.push_back(bus(1'b1, 1'b1, 8'hAA, 0, 1'b1, 8'h00, 1'b0, 1'b0));
      vecs.push_back(bus(1'b1, 1'b1, 8'h11, 2, 1'b1, 8'hAA, 1'b0, 1'b0));
      vecs.push_back(bus(1'b1, 1'b1, 8'h22, 2, 1'b1, 8'h11, 1'b0, 1'b0));
      vecs.push_back(bus(1'b1, 1'b1, 8'h33, 2, 1'b1, 8'h22, 1'b0, 1'b0));
      vecs.push_back(bus(1'b1, 1'b1, 8'h44, 2, 1'b1, 8'h33, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h44, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0, 1'b0));
      // Write reg 1 = 0x02, nxt on alternate cycles.
      vecs.push_back(mk(1'b1, 1'b0, 6'h01, 8'h02, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h81, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h81, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h02, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h02, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b1, 1'b1));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0, 1'b0));
      // Write reg 3 = 0x04 aborted by dir one cycle into TXCMD; a busy request is ignored.
      vecs.push_back(mk(1'b1, 1'b0, 6'h03, 8'h04, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0, 1'b0));
      vecs.push_back(bus(1'b1, 1'b1, 8'h00, 0, 1'b1, 8'h83, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 6'h3F, 8'hEE, 1'b1, 1'b1, 8'h05, 2, 1'b1, 8'h00, 1'b0, 1'b0));
      vecs.push_back(bus(1'b1, 1'b1, 8'h06, 2, 1'b1, 8'h05, 1'b0, 1'b0));
      vecs.push_back(bus(1'b1, 1'b1, 8'h07, 2, 1'b1, 8'h06, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h07, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h83, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h83, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h04, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b1, 1'b1));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0, 1'b0));
      // Read reg 6; the PHY returns 0x5A, which must not appear as an RX CMD.
      vecs.push_back(mk(1'b1, 1'b1, 6'h06, 8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'hC6, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hC6, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0, 1'b0));
      vecs.push_back(bus(1'b1, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0, 1'b0));
      vecs.push_back(bus(1'b1, 1'b0, 8'h5A, 0, 1'b1, 8'h00, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h5A, 1'b0, 1'b0));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0, 1'b1));
      vecs.push_back(bus(1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0, 1'b0));

      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("reset data", data, 8'h00);
         check("reset stp", stp, 1'b0);
         check("reset reg_done", reg_done, 1'b0);
         check("reset reg_data_read", reg_data_read, 8'h00);
         check("reset rx_cmd", rx_cmd, 8'h00);
         check("reset rx_data", rx_data, 8'h00);
      end

      run_vecs();

      check("reg_data_read", reg_data_read, 8'h5A);
      check("rx_cmd held", rx_cmd, 8'h42);
      check("rx_data held", rx_data, 8'h07);
      check("rx_cmd_valid pulses", 32'(cmdv_cnt), 32'd2);
      check("rx_valid pulses", 32'(rxv_cnt), 32'd7);
      check("cmd scoreboard empty", 32'(cmd_q.size()), 32'd0);
      check("pkt scoreboard empty", 32'(pkt_q.size()), 32'd0);
`ifdef ULPI_RXCMD_DECODE_EN
      check("line_state", line_state, 2'b10);
      check("vbus_state", vbus_state, 2'b00);
      check("rx_event", rx_event, 2'b00);
`else
      check("line_state", line_state, 2'b00);
      check("vbus_state", vbus_state, 2'b00);
      check("rx_event", rx_event, 2'b00);
`endif

      // Reset in the middle of a write: no completion, bus back to idle, request dropped.
      reg_enable = 1'b1; reg_read_nwrite = 1'b0; reg_addr = 6'h0A; reg_data_write = 8'h55;
      @(negedge clk);
      reg_enable = 1'b0;
      check("midreset txcmd", data, 8'h8A);
      reset = 1'b0;
      @(negedge clk);
      check("midreset data", data, 8'h00);
      check("midreset stp", stp, 1'b0);
      check("midreset reg_done", reg_done, 1'b0);
      check("midreset reg_data_read", reg_data_read, 8'h00);
      reset = 1'b1;
      nxt   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("postreset data %0d", k), data, 8'h00);
         check($sformatf("postreset reg_done %0d", k), reg_done, 1'b0);
      end
      check("reg_done total", 32'(done_cnt), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ulpi_link.md
Name: ulpi_link

Overview:
ULPI link-layer controller sitting between the ULPI PHY pins (ulpi_if) and the system-side register/receive interface (ulpi_link_if). It owns the 8-bit ULPI bus while dir=0 and issues register write/read TX CMDs with the nxt/stp handshake. While dir=1 it captures RX CMD bytes and received packet bytes, handling bus turnaround and PHY-initiated aborts.

Parameters:
None. ULPI widths are fixed by the standard: 8-bit data, 6-bit register address.

Ports:
clk  in  1  ULPI clock from PHY; all logic on rising edge
reset  in  1  synchronous, active-low reset
data  inout  8  ULPI data bus; link drives only when dir=0, Hi-Z when dir=1
dir  in  1  PHY owns bus when 1
nxt  in  1  PHY throttle / byte-accept strobe
stp  out  1  link stop strobe
reg_addr  in  6  register address
reg_data_write  in  8  write data
reg_read_nwrite  in  1  1=read, 0=write
reg_enable  in  1  single-cycle request strobe
reg_done  out  1  one-cycle completion pulse
reg_data_read  out  8  last read value, held until next read completes
rx_cmd  out  8  last RX CMD byte, held
rx_cmd_valid  out  1  one-cycle pulse per RX CMD
rx_data  out  8  received packet byte
rx_valid  out  1  one-cycle pulse per packet byte

Behaviour:
- Reset (reset=0 at clk edge): state IDLE, stp=0, data output 0x00 (driven only if dir=0), reg_done=0, reg_data_read=0x00, rx_cmd=0x00, rx_cmd_valid=0, rx_valid=0, rx_data=0x00, pending request cleared. Reset mid-operation aborts with no reg_done.
- Turnaround: any cycle where registered dir differs from current dir. Data is neither driven nor sampled in that cycle.
- Receive (dir=1, not turnaround): nxt=0 means the byte is an RX CMD; latch into rx_cmd and pulse rx_cmd_valid next cycle. nxt=1 means a packet byte; latch into rx_data and pulse rx_valid next cycle.
- IDLE with dir=0: drive 0x00, stp=0. A nonzero byte is only ever driven as a TX CMD.
- reg_enable is accepted only in IDLE; it latches addr, write data and direction as the pending request. While busy, reg_enable is ignored.
- Write sequence:
  - TXCMD: drive 0x80|addr, hold until nxt=1.
  - WDATA: drive reg_data_write, hold until nxt=1.
  - STP: drive 0x00 with stp=1 for one cycle, pulse reg_done the same cycle, return to IDLE.
- Read sequence:
  - TXCMD: drive 0xC0|addr, hold until nxt=1.
  - RTURN1: wait for dir=1 (turnaround).
  - RDATA: capture data into reg_data_read.
  - RTURN2: wait for dir=0 turnaround, then pulse reg_done and return to IDLE.
- Abort: if dir rises in TXCMD or WDATA before the phase completes, release the bus immediately, keep the request pending, and service receive. After the dir-fall turnaround, restart the command from TXCMD. No reg_done on abort.
- dir=1 in IDLE with a pending request: the request waits; receive has priority.
- stp is never asserted while dir=1.

Optional Feature:
ULPI_RXCMD_DECODE_EN.
- Defined: extra outputs line_state[1:0]=rx_cmd[1:0], vbus_state[1:0]=rx_cmd[3:2] and rx_event[1:0]=rx_cmd[5:4], all updated with rx_cmd.
- Undefined: these ports exist and are tied to 0.

Decomposition:
- ulpi_pkg holds:
  - TX CMD prefixes: TXCMD_REGW=2'b10, TXCMD_REGR=2'b11, TXCMD_IDLE=8'h00.
  - Link state enum: IDLE, TXCMD, WDATA, STP, RTURN1, RDATA, RTURN2.
  - RX CMD field offsets.
- One sub-module, ulpi_link_rx: turnaround detection plus rx_cmd/rx_data capture.

Test Plan:
- Reset low, then high. Next 2 clocks: data=0x00, stp=0, reg_done=0.
- PHY raises dir, then drives 0x23 then 0x42 as RX CMDs with nxt=0 (each preceded by turnaround) -> rx_cmd=0x23 then 0x42, one rx_cmd_valid pulse each; link releases data.
- PHY raises dir with nxt=1 and sends 4 bytes -> exactly 4 rx_valid pulses with matching rx_data; no bytes sampled in turnaround cycles.
- write reg 1 = 0x02, PHY asserts nxt on alternate cycles -> bus shows 0x81 until nxt, then 0x02 until nxt, then stp=1 with 0x00 for one cycle; reg_done pulses once.
- write reg 3 = 0x04 while PHY raises dir one cycle into TXCMD with 3 incoming bytes -> 3 rx_valid pulses; after dir falls, 0x83 and 0x04 are reissued; a single reg_done.
- read reg 6, PHY returns 0x5A after turnaround -> bus shows 0xC6; reg_data_read=0x5A and reg_done pulses after the second turnaround.
